// File: rtl/lc4_div_pkg.sv
// Shared definitions for the LC4 iterative restoring divider.
package lc4_div_pkg;
  localparam int WORD_W = 16;
  localparam int STEPS  = 16;
  localparam int CNT_W  = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/lc4_div_step.sv
// One restoring division step: shift {rem,quo} left, conditionally subtract divisor.
module lc4_div_step
  import lc4_div_pkg::*;
(
  input  logic [WORD_W-1:0] rem_i,
  input  logic [WORD_W-1:0] quo_i,
  input  logic [WORD_W-1:0] divisor_i,
  output logic [WORD_W-1:0] rem_o,
  output logic [WORD_W-1:0] quo_o
);
  logic [WORD_W:0] shifted;

  // The compare needs 17 bits, but since rem < divisor the difference always fits in 16.
  always_comb begin
    shifted = {rem_i, quo_i[WORD_W-1]};
    rem_o   = shifted[WORD_W-1:0];
    quo_o   = {quo_i[WORD_W-2:0], 1'b0};
    if (shifted >= {1'b0, divisor_i}) begin
      rem_o = shifted[WORD_W-1:0] - divisor_i;
      quo_o = {quo_i[WORD_W-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/lc4_div_iter.sv
// LC4 16-bit unsigned iterative divider: valid/ready handshake, one step per gwe edge.
module lc4_div_iter
  import lc4_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              gwe,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WORD_W-1:0] i_dividend,
  input  logic [WORD_W-1:0] i_divisor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_quotient,
  output logic [WORD_W-1:0] o_remainder
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] quo_q, quo_d;
  logic [WORD_W-1:0] rem_q, rem_d;
  logic [WORD_W-1:0] div_q, div_d;
  logic [WORD_W-1:0] stepRem, stepQuo;

  lc4_div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          // Divide-by-zero skips the iteration and reports 0/0.
          if (i_divisor == '0) begin
            quo_d   = '0;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            div_d   = i_divisor;
            quo_d   = i_dividend;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        quo_d = stepQuo;
        rem_d = stepRem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
    end else if (gwe) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;
endmodule

// File: tb/tb_lc4_div_iter.sv
// Directed self-checking bench for lc4_div_iter with hand-computed results.
module tb_lc4_div_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  int errors = 0;
  int checks = 0;
  int edges;
  int strayValid;

  lc4_div_iter dut (
    .clk         (clk),
    .rst         (rst),
    .gwe         (gwe),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b);
    i_valid    = v;
    i_dividend = a;
    i_divisor  = b;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
    end
  endtask

  // Accept a/b, scramble inputs while busy, optionally stall gwe, then check latency and result.
  task automatic runDiv(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int stallAt, input int stallLen, input int expLat,
                        input logic [15:0] expQ, input logic [15:0] expR);
    applyStimulus(1'b1, a, b);
    tick();
    edges = 0;
    while (!o_valid && edges < 60) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom));
      gwe = !(stallAt >= 0 && edges >= stallAt && edges < stallAt + stallLen);
      tick();
      edges++;
    end
    gwe = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput({tag, "_latency"}, 16'(edges), 16'(expLat));
    checkOutput({tag, "_valid"}, {15'd0, o_valid}, 16'd1);
    checkOutput({tag, "_quotient"}, o_quotient, expQ);
    checkOutput({tag, "_remainder"}, o_remainder, expR);
  endtask

  task automatic retire(input string tag);
    i_ready = 1'b1;
    tick();
    checkOutput({tag, "_ready_after"}, {15'd0, o_ready}, 16'd1);
    checkOutput({tag, "_valid_after"}, {15'd0, o_valid}, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    gwe = 1'b0;
    i_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    gwe = 1'b1;
    checkOutput("reset_ready", {15'd0, o_ready}, 16'd1);
    checkOutput("reset_valid", {15'd0, o_valid}, 16'd0);
    checkOutput("reset_quotient", o_quotient, 16'h0000);
    checkOutput("reset_remainder", o_remainder, 16'h0000);

    runDiv("d100_7", 16'd100, 16'd7, -1, 0, 16, 16'd14, 16'd2);
    retire("d100_7");

    runDiv("dFFFF_1", 16'hFFFF, 16'h0001, -1, 0, 16, 16'hFFFF, 16'h0000);
    retire("dFFFF_1");

    runDiv("d8000_FFFF", 16'h8000, 16'hFFFF, -1, 0, 16, 16'h0000, 16'h8000);
    retire("d8000_FFFF");

    runDiv("d1234_0", 16'd1234, 16'd0, -1, 0, 0, 16'd0, 16'd0);
    retire("d1234_0");

    i_ready = 1'b0;
    runDiv("d50_3", 16'd50, 16'd3, -1, 0, 16, 16'd16, 16'd2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k[0], 16'($urandom), 16'($urandom));
      tick();
      checkOutput("bp_valid", {15'd0, o_valid}, 16'd1);
      checkOutput("bp_ready", {15'd0, o_ready}, 16'd0);
      checkOutput("bp_quotient", o_quotient, 16'd16);
      checkOutput("bp_remainder", o_remainder, 16'd2);
    end
    applyStimulus(1'b0, 16'h0, 16'h0);
    retire("d50_3");

    runDiv("d200_9_stall", 16'd200, 16'd9, 5, 3, 19, 16'd22, 16'd2);
    retire("d200_9_stall");

    applyStimulus(1'b1, 16'd1000, 16'd10);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) tick();
    checkOutput("abort_busy_ready", {15'd0, o_ready}, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_ready", {15'd0, o_ready}, 16'd1);
    checkOutput("abort_valid", {15'd0, o_valid}, 16'd0);
    checkOutput("abort_quotient", o_quotient, 16'h0000);
    checkOutput("abort_remainder", o_remainder, 16'h0000);
    strayValid = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_valid) strayValid++;
    end
    checkOutput("abort_no_result", 16'(strayValid), 16'd0);

    runDiv("d1000_10", 16'd1000, 16'd10, -1, 0, 16, 16'd100, 16'd0);
    retire("d1000_10");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
